// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, ID/EX FSM encoding and control-bundle layout
package mips_pkg;

  // Default widths for the pipeline registers
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 6;
  localparam int CONT_W = 16;

  // HALT propagation states of the ID/EX register
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALTING = 2'd1,
    ST_HALTED  = 2'd2
  } halt_state_t;

  // Bit positions inside the EX/M/WB control bundle
  localparam int CTRL_ALU_OP_LSB = 0;
  localparam int CTRL_ALU_OP_MSB = 3;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_MEM_TO_REG = 5;

endpackage

// File: rtl/contador_burbujas.sv
// rtl/contador_burbujas.sv - saturating up-counter with enable and sync active-high reset
module contador_burbujas #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  // Count enabled events, holding at all-ones instead of wrapping
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (enable && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_latch.sv
// rtl/id_ex_latch.sv - ID/EX pipeline register with bubble, flush and HALT tracking (option: ID_EX_BUBBLE_COUNTER_EN)
module id_ex_latch
  import mips_pkg::*;
#(
  parameter int CANT_BITS_ADDR_REGISTROS = ADDR_W,
  parameter int CANT_BITS_REGISTROS      = DATA_W,
  parameter int CANT_BITS_CTRL_EX        = CTRL_W,
  parameter int CANT_BITS_CONTADOR       = CONT_W
) (
  input  logic                                i_clock,
  input  logic                                i_reset,
  input  logic                                i_enable_etapa,
  input  logic                                i_bit_burbuja,
  input  logic                                i_flush,
  input  logic                                i_halt_id,
  input  logic [CANT_BITS_REGISTROS-1:0]      i_pc_plus4,
  input  logic [CANT_BITS_REGISTROS-1:0]      i_reg_a,
  input  logic [CANT_BITS_REGISTROS-1:0]      i_reg_b,
  input  logic [CANT_BITS_REGISTROS-1:0]      i_inmediato,
  input  logic [CANT_BITS_ADDR_REGISTROS-1:0] i_rs,
  input  logic [CANT_BITS_ADDR_REGISTROS-1:0] i_rt,
  input  logic [CANT_BITS_ADDR_REGISTROS-1:0] i_rd,
  input  logic                                i_reg_dst,
  input  logic                                i_read_mem,
  input  logic                                i_write_mem,
  input  logic                                i_reg_write,
  input  logic [CANT_BITS_CTRL_EX-1:0]        i_ctrl_ex,
  output logic [CANT_BITS_REGISTROS-1:0]      o_pc_plus4,
  output logic [CANT_BITS_REGISTROS-1:0]      o_reg_a,
  output logic [CANT_BITS_REGISTROS-1:0]      o_reg_b,
  output logic [CANT_BITS_REGISTROS-1:0]      o_inmediato,
  output logic [CANT_BITS_ADDR_REGISTROS-1:0] o_rs,
  output logic [CANT_BITS_ADDR_REGISTROS-1:0] o_rt,
  output logic [CANT_BITS_ADDR_REGISTROS-1:0] o_registro_destino_ex,
  output logic                                o_read_mem_ex,
  output logic                                o_write_mem_ex,
  output logic                                o_reg_write_ex,
  output logic [CANT_BITS_CTRL_EX-1:0]        o_ctrl_ex,
  output logic                                o_valid_ex,
  output logic                                o_halt_ex,
  output logic                                o_halted,
  output logic [CANT_BITS_CONTADOR-1:0]       o_cant_burbujas
);

  halt_state_t state_q;
  halt_state_t state_d;

  logic stall_bubble;
  logic capture;

  // A stall only counts when it is not overridden by a flush; capture only in RUN
  always_comb begin
    stall_bubble = i_enable_etapa && !i_flush && i_bit_burbuja;
    capture      = i_enable_etapa && !i_flush && !i_bit_burbuja && (state_q == ST_RUN);
  end

  // HALT FSM state register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // HALT FSM next state: only a real HALT capture leaves RUN, HALTED is sticky
  always_comb begin
    state_d = state_q;
    if (i_enable_etapa) begin
      case (state_q)
        ST_RUN:     if (capture && i_halt_id) state_d = ST_HALTING;
        ST_HALTING: state_d = ST_HALTED;
        ST_HALTED:  state_d = ST_HALTED;
        default:    state_d = ST_RUN;
      endcase
    end
  end

  // HALT FSM outputs
  always_comb begin
    o_halted = (state_q == ST_HALTED);
  end

  // Pipeline register: hold when disabled, capture ID, otherwise insert a bubble
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_pc_plus4            <= '0;
      o_reg_a               <= '0;
      o_reg_b               <= '0;
      o_inmediato           <= '0;
      o_rs                  <= '0;
      o_rt                  <= '0;
      o_registro_destino_ex <= '0;
      o_read_mem_ex         <= 1'b0;
      o_write_mem_ex        <= 1'b0;
      o_reg_write_ex        <= 1'b0;
      o_ctrl_ex             <= '0;
      o_valid_ex            <= 1'b0;
      o_halt_ex             <= 1'b0;
    end else if (i_enable_etapa) begin
      if (capture) begin
        o_pc_plus4            <= i_pc_plus4;
        o_reg_a               <= i_reg_a;
        o_reg_b               <= i_reg_b;
        o_inmediato           <= i_inmediato;
        o_rs                  <= i_rs;
        o_rt                  <= i_rt;
        o_registro_destino_ex <= i_reg_dst ? i_rd : i_rt;
        o_read_mem_ex         <= i_read_mem;
        o_write_mem_ex        <= i_write_mem;
        o_reg_write_ex        <= i_reg_write;
        o_ctrl_ex             <= i_ctrl_ex;
        o_valid_ex            <= 1'b1;
        o_halt_ex             <= i_halt_id;
      end else begin
        // Clearing the destination and read-mem keeps the hazard unit from re-stalling on a bubble
        o_pc_plus4            <= '0;
        o_reg_a               <= '0;
        o_reg_b               <= '0;
        o_inmediato           <= '0;
        o_rs                  <= '0;
        o_rt                  <= '0;
        o_registro_destino_ex <= '0;
        o_read_mem_ex         <= 1'b0;
        o_write_mem_ex        <= 1'b0;
        o_reg_write_ex        <= 1'b0;
        o_ctrl_ex             <= '0;
        o_valid_ex            <= 1'b0;
        o_halt_ex             <= 1'b0;
      end
    end
  end

`ifdef ID_EX_BUBBLE_COUNTER_EN
  contador_burbujas #(
    .WIDTH(CANT_BITS_CONTADOR)
  ) u_contador_burbujas (
    .clock  (i_clock),
    .reset  (i_reset),
    .enable (stall_bubble),
    .count  (o_cant_burbujas)
  );
`else
  logic unused_stall;
  assign unused_stall    = stall_bubble;
  assign o_cant_burbujas = '0;
`endif

endmodule

// File: tb/tb_id_ex_latch.sv
// tb/tb_id_ex_latch.sv - scoreboard bench for id_ex_latch with directed vectors
module tb_id_ex_latch;

  localparam int CW = 2;
`ifdef ID_EX_BUBBLE_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        reg_dst;
    logic        rm;
    logic        wm;
    logic        rw;
    logic [5:0]  ctrl;
    logic        halt;
  } in_t;

  typedef struct packed {
    logic [31:0]   pc;
    logic [31:0]   a;
    logic [31:0]   b;
    logic [31:0]   imm;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    dst;
    logic          rm;
    logic          wm;
    logic          rw;
    logic [5:0]    ctrl;
    logic          valid;
    logic          halt;
    logic          halted;
    logic [CW-1:0] cnt;
  } out_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, bub, flush;
  in_t         vin;
  logic [31:0] o_pc, o_a, o_b, o_imm;
  logic [4:0]  o_rs, o_rt, o_dst;
  logic        o_rm, o_wm, o_rw, o_valid, o_halt, o_halted;
  logic [5:0]  o_ctrl;
  logic [CW-1:0] o_cnt;

  id_ex_latch #(
    .CANT_BITS_ADDR_REGISTROS(5),
    .CANT_BITS_REGISTROS     (32),
    .CANT_BITS_CTRL_EX       (6),
    .CANT_BITS_CONTADOR      (CW)
  ) dut (
    .i_clock              (clk),
    .i_reset              (rst),
    .i_enable_etapa       (en),
    .i_bit_burbuja        (bub),
    .i_flush              (flush),
    .i_halt_id            (vin.halt),
    .i_pc_plus4           (vin.pc),
    .i_reg_a              (vin.a),
    .i_reg_b              (vin.b),
    .i_inmediato          (vin.imm),
    .i_rs                 (vin.rs),
    .i_rt                 (vin.rt),
    .i_rd                 (vin.rd),
    .i_reg_dst            (vin.reg_dst),
    .i_read_mem           (vin.rm),
    .i_write_mem          (vin.wm),
    .i_reg_write          (vin.rw),
    .i_ctrl_ex            (vin.ctrl),
    .o_pc_plus4           (o_pc),
    .o_reg_a              (o_a),
    .o_reg_b              (o_b),
    .o_inmediato          (o_imm),
    .o_rs                 (o_rs),
    .o_rt                 (o_rt),
    .o_registro_destino_ex(o_dst),
    .o_read_mem_ex        (o_rm),
    .o_write_mem_ex       (o_wm),
    .o_reg_write_ex       (o_rw),
    .o_ctrl_ex            (o_ctrl),
    .o_valid_ex           (o_valid),
    .o_halt_ex            (o_halt),
    .o_halted             (o_halted),
    .o_cant_burbujas      (o_cnt)
  );

  out_t  exp_q[$];
  string tag_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  function automatic logic [CW-1:0] ecnt(input logic [CW-1:0] c);
    return CNT_EN ? c : '0;
  endfunction

  function automatic out_t cap(input in_t v, input logic [CW-1:0] c);
    out_t e;
    e.pc = v.pc; e.a = v.a; e.b = v.b; e.imm = v.imm;
    e.rs = v.rs; e.rt = v.rt; e.dst = v.reg_dst ? v.rd : v.rt;
    e.rm = v.rm; e.wm = v.wm; e.rw = v.rw; e.ctrl = v.ctrl;
    e.valid = 1'b1; e.halt = v.halt; e.halted = 1'b0; e.cnt = ecnt(c);
    return e;
  endfunction

  function automatic out_t bubble(input logic hd, input logic [CW-1:0] c);
    out_t e;
    e = '0;
    e.halted = hd;
    e.cnt = ecnt(c);
    return e;
  endfunction

  // Drive one edge worth of inputs and queue the output expected after that edge
  task automatic step(input string tag, input in_t v, input logic r, input logic e,
                      input logic f, input logic s, input out_t x);
    @(negedge clk);
    vin = v; rst = r; en = e; flush = f; bub = s;
    exp_q.push_back(x);
    tag_q.push_back(tag);
  endtask

  // Monitor: compare DUT outputs shortly after each edge that has a queued expectation
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      out_t  e;
      out_t  g;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      g = {o_pc, o_a, o_b, o_imm, o_rs, o_rt, o_dst, o_rm, o_wm, o_rw, o_ctrl,
           o_valid, o_halt, o_halted, o_cnt};
      n_vec++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", t, g, e);
      end
    end
  end

  in_t v1, v2, v3, v4, vh;
  out_t h3;

  initial begin
    v1 = '{pc:32'h4, a:32'hDEADBEEF, b:32'h0000_1111, imm:32'hFFFF_FFF0, rs:5'd2, rt:5'd7,
           rd:5'd3, reg_dst:1'b0, rm:1'b1, wm:1'b0, rw:1'b1, ctrl:6'h15, halt:1'b0};
    v2 = '{pc:32'h8, a:32'h1234_5678, b:32'hCAFE_F00D, imm:32'h40, rs:5'd31, rt:5'd1,
           rd:5'd9, reg_dst:1'b1, rm:1'b0, wm:1'b1, rw:1'b0, ctrl:6'h2A, halt:1'b0};
    v3 = '{pc:32'hC, a:32'hA5A5_A5A5, b:32'h5A5A_5A5A, imm:32'h1, rs:5'd4, rt:5'd5,
           rd:5'd6, reg_dst:1'b1, rm:1'b1, wm:1'b1, rw:1'b1, ctrl:6'h3F, halt:1'b0};
    v4 = '{pc:32'h10, a:32'h1, b:32'h2, imm:32'h3, rs:5'd8, rt:5'd10,
           rd:5'd11, reg_dst:1'b0, rm:1'b0, wm:1'b0, rw:1'b1, ctrl:6'h01, halt:1'b0};
    vh = '{pc:32'h14, a:32'h0, b:32'h0, imm:32'h0, rs:5'd0, rt:5'd0,
           rd:5'd0, reg_dst:1'b0, rm:1'b0, wm:1'b0, rw:1'b0, ctrl:6'h00, halt:1'b1};
    vin = '0; rst = 1'b1; en = 1'b1; flush = 1'b0; bub = 1'b0;

    step("reset_0",        v1, 1, 1, 0, 0, bubble(0, 0));
    step("reset_1",        v2, 1, 1, 0, 0, bubble(0, 0));
    step("cap_rt",         v1, 0, 1, 0, 0, cap(v1, 0));
    step("cap_rd",         v2, 0, 1, 0, 0, cap(v2, 0));
    step("stall_1",        v3, 0, 1, 0, 1, bubble(0, 1));
    step("flush_stall",    v3, 0, 1, 1, 1, bubble(0, 1));
    step("flush_only",     v1, 0, 1, 1, 0, bubble(0, 1));
    step("stall_2",        v2, 0, 1, 0, 1, bubble(0, 2));
    step("stall_3",        v1, 0, 1, 0, 1, bubble(0, 3));
    h3 = cap(v3, 3);
    step("cap_v3",         v3, 0, 1, 0, 0, h3);
    step("hold_0",         v4, 0, 0, 0, 0, h3);
    step("hold_stall",     v1, 0, 0, 0, 1, h3);
    step("sat_stall_4",    v2, 0, 1, 0, 1, bubble(0, 3));
    step("sat_stall_5",    v2, 0, 1, 0, 1, bubble(0, 3));
    step("cap_v4",         v4, 0, 1, 0, 0, cap(v4, 3));
    step("reset_en_low",   v1, 1, 0, 0, 0, bubble(0, 0));
    step("halt_flushed",   vh, 0, 1, 1, 0, bubble(0, 0));
    step("halt_stalled",   vh, 0, 1, 0, 1, bubble(0, 1));
    step("cap_still_run",  v1, 0, 1, 0, 0, cap(v1, 1));
    step("halt_capture",   vh, 0, 1, 0, 0, cap(vh, 1));
    step("halting_bubble", v2, 0, 1, 0, 0, bubble(1, 1));
    step("halted_1",       v3, 0, 1, 0, 0, bubble(1, 1));
    step("halted_en_low",  v4, 0, 0, 0, 0, bubble(1, 1));
    step("halted_2",       v4, 0, 1, 0, 0, bubble(1, 1));
    step("halted_reset",   v1, 1, 1, 0, 0, bubble(0, 0));
    step("cap_after_rst",  v2, 0, 1, 0, 0, cap(v2, 0));

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
